fifo_data_pkt_buf: RTL and testbench



---
 rtl/fifo_data_pkt_pkg.sv | 35 +++
 rtl/fifo_data_pkt_buf_if.sv | 62 ++++++
 rtl/fifo_data_pkt_sync.sv | 38 +++
 rtl/fifo_data_pkt_buf.sv | 162 ++++++++++++++++
 tb/tb_fifo_data_pkt_buf.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_data_pkt_pkg.sv
// ---------------------------------------------------------------------------
// fifo_data_pkt_pkg
// Shared defaults and pointer-coding helpers for the fifo_data_pkt_buf FIFO.
//   DEF_*      : default geometry and flag thresholds
//   ptr_t      : widest pointer the FIFO supports (ADDR_WIDTH 10 -> 11 bits)
//   bin2gray   : binary -> reflected Gray code
//   gray2bin   : reflected Gray code -> binary
// Narrower pointers are zero-extended into ptr_t. Leading zeros do not change
// either conversion, so callers simply truncate the result back to their width.
// ---------------------------------------------------------------------------
package fifo_data_pkt_pkg;

  localparam int DEF_ADDR_WIDTH       = 10;
  localparam int DEF_DATA_WIDTH       = 8;
  localparam int DEF_OUT_REG          = 0;
  localparam int DEF_ALMOST_FULL_NUM  = 11;
  localparam int DEF_ALMOST_EMPTY_NUM = 4;

  localparam int PTR_MAX_W = 11;
  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_data_pkt_buf_if.sv
// ---------------------------------------------------------------------------
// fifo_data_pkt_buf_if
// Producer/consumer bus of the packet-byte FIFO.
//   wr_data, wr_en                         : write request (producer -> FIFO)
//   full, almost_full, wr_water_level      : write-side status (FIFO -> producer)
//   rd_en                                  : read request (consumer -> FIFO)
//   rd_data, empty, almost_empty,
//   rd_water_level                         : read-side data/status (FIFO -> consumer)
//   overflow, underflow                    : sticky error flags, present only when
//                                            FIFO_DATA_PKT_ERR_FLAG_EN is defined
// Modports: master = producer/consumer side, slave = the FIFO.
// ---------------------------------------------------------------------------
interface fifo_data_pkt_buf_if
  import fifo_data_pkt_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_water_level;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rd_water_level;

`ifdef FIFO_DATA_PKT_ERR_FLAG_EN
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_data, wr_en, rd_en,
    input  full, almost_full, wr_water_level,
    input  rd_data, empty, almost_empty, rd_water_level,
    input  overflow, underflow
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output full, almost_full, wr_water_level,
    output rd_data, empty, almost_empty, rd_water_level,
    output overflow, underflow
  );
`else
  modport master (
    output wr_data, wr_en, rd_en,
    input  full, almost_full, wr_water_level,
    input  rd_data, empty, almost_empty, rd_water_level
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output full, almost_full, wr_water_level,
    output rd_data, empty, almost_empty, rd_water_level
  );
`endif

endinterface

// File: rtl/fifo_data_pkt_sync.sv
// ---------------------------------------------------------------------------
// fifo_data_pkt_sync
// Two-flop synchronizer for a Gray-coded pointer entering the clk domain.
// Only one bit of a Gray pointer changes per source update, so each bit can be
// synchronized independently without producing an incoherent value.
//   clk : destination clock
//   rst : asynchronous active-high reset of the destination domain
//   d   : Gray pointer from the other domain
//   q   : synchronized Gray pointer
// ---------------------------------------------------------------------------
module fifo_data_pkt_sync #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta_reg[gi] <= 1'b0;
        sync_reg[gi] <= 1'b0;
      end else begin
        meta_reg[gi] <= d[gi];
        sync_reg[gi] <= meta_reg[gi];
      end
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/fifo_data_pkt_buf.sv
// ---------------------------------------------------------------------------
// fifo_data_pkt_buf
// Dual-clock FIFO for packet bytes with full/empty, almost-full/almost-empty
// flags and per-side fill levels. Gray pointers cross domains through
// fifo_data_pkt_sync, so both flags are conservative.
// Ports:
//   wr_clk, wr_rst : write clock, async active-high write reset
//   rd_clk, rd_rst : read clock, async active-high read reset
//   bus            : fifo_data_pkt_buf_if.slave (data, requests, flags, levels)
// Parameters: ADDR_WIDTH (depth 2**ADDR_WIDTH), DATA_WIDTH, OUT_REG (extra
// rd_data stage), ALMOST_FULL_NUM, ALMOST_EMPTY_NUM.
// Optional: FIFO_DATA_PKT_ERR_FLAG_EN adds sticky overflow/underflow flags.
// ---------------------------------------------------------------------------
module fifo_data_pkt_buf
  import fifo_data_pkt_pkg::*;
#(
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int OUT_REG          = DEF_OUT_REG,
  parameter int ALMOST_FULL_NUM  = DEF_ALMOST_FULL_NUM,
  parameter int ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst,
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  fifo_data_pkt_buf_if.slave   bus
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] AF_LVL = PW'(ALMOST_FULL_NUM);
  localparam logic [PW-1:0] AE_LVL = PW'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic          wr_fire;
  logic [PW-1:0] wptr_bin_reg, wptr_gray_reg;
  logic [PW-1:0] wptr_bin_next, wptr_gray_next;
  logic [PW-1:0] rptr_sync, rptr_sync_bin, full_cmp, wr_level_calc;
  logic [PW-1:0] wr_level_reg;
  logic          full_reg, almost_full_reg;

  assign wr_fire        = bus.wr_en && !full_reg;
  assign wptr_bin_next  = wptr_bin_reg + {{ADDR_WIDTH{1'b0}}, wr_fire};
  assign wptr_gray_next = PW'(bin2gray(ptr_t'(wptr_bin_next)));
  assign rptr_sync_bin  = PW'(gray2bin(ptr_t'(rptr_sync)));
  // Writer is exactly one lap ahead: top two Gray bits inverted, rest equal.
  assign full_cmp       = {~rptr_sync[PW-1:PW-2], rptr_sync[PW-3:0]};
  assign wr_level_calc  = wptr_bin_reg - rptr_sync_bin;

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wptr_bin_reg    <= '0;
      wptr_gray_reg   <= '0;
      full_reg        <= 1'b0;
      wr_level_reg    <= '0;
      almost_full_reg <= 1'b0;
    end else begin
      wptr_bin_reg    <= wptr_bin_next;
      wptr_gray_reg   <= wptr_gray_next;
      // Look at the post-write pointer so full rises on the filling edge.
      full_reg        <= (wptr_gray_next == full_cmp);
      wr_level_reg    <= wr_level_calc;
      almost_full_reg <= (wr_level_calc >= AF_LVL);
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_fire) begin
      mem[wptr_bin_reg[ADDR_WIDTH-1:0]] <= bus.wr_data;
    end
  end

  fifo_data_pkt_sync #(.WIDTH(PW)) u_rptr_sync (
    .clk (wr_clk),
    .rst (wr_rst),
    .d   (rptr_gray_reg),
    .q   (rptr_sync)
  );

  // ---------------- read domain ----------------
  logic                  rd_fire;
  logic [PW-1:0]         rptr_bin_reg, rptr_gray_reg;
  logic [PW-1:0]         rptr_bin_next, rptr_gray_next;
  logic [PW-1:0]         wptr_sync, wptr_sync_bin, rd_level_calc;
  logic [PW-1:0]         rd_level_reg;
  logic                  empty_reg, almost_empty_reg;
  logic [DATA_WIDTH-1:0] rd_q_reg;

  assign rd_fire        = bus.rd_en && !empty_reg;
  assign rptr_bin_next  = rptr_bin_reg + {{ADDR_WIDTH{1'b0}}, rd_fire};
  assign rptr_gray_next = PW'(bin2gray(ptr_t'(rptr_bin_next)));
  assign wptr_sync_bin  = PW'(gray2bin(ptr_t'(wptr_sync)));
  assign rd_level_calc  = wptr_sync_bin - rptr_bin_reg;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rptr_bin_reg     <= '0;
      rptr_gray_reg    <= '0;
      empty_reg        <= 1'b1;
      rd_level_reg     <= '0;
      almost_empty_reg <= 1'b1;
      rd_q_reg         <= '0;
    end else begin
      rptr_bin_reg     <= rptr_bin_next;
      rptr_gray_reg    <= rptr_gray_next;
      empty_reg        <= (rptr_gray_next == wptr_sync);
      rd_level_reg     <= rd_level_calc;
      almost_empty_reg <= (rd_level_calc <= AE_LVL);
      if (rd_fire) begin
        rd_q_reg <= mem[rptr_bin_reg[ADDR_WIDTH-1:0]];
      end
    end
  end

  fifo_data_pkt_sync #(.WIDTH(PW)) u_wptr_sync (
    .clk (rd_clk),
    .rst (rd_rst),
    .d   (wptr_gray_reg),
    .q   (wptr_sync)
  );

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] rd_out_reg;
    always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) rd_out_reg <= '0;
      else        rd_out_reg <= rd_q_reg;
    end
    assign bus.rd_data = rd_out_reg;
  end else begin : g_no_out_reg
    assign bus.rd_data = rd_q_reg;
  end

  assign bus.full           = full_reg;
  assign bus.almost_full    = almost_full_reg;
  assign bus.wr_water_level = wr_level_reg;
  assign bus.empty          = empty_reg;
  assign bus.almost_empty   = almost_empty_reg;
  assign bus.rd_water_level = rd_level_reg;

`ifdef FIFO_DATA_PKT_ERR_FLAG_EN
  logic overflow_reg, underflow_reg;

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst)                      overflow_reg <= 1'b0;
    else if (bus.wr_en && full_reg)  overflow_reg <= 1'b1;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst)                      underflow_reg <= 1'b0;
    else if (bus.rd_en && empty_reg) underflow_reg <= 1'b1;
  end

  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;
`else
  // Error flags not built: no overflow/underflow state.
`endif

endmodule

// File: tb/tb_fifo_data_pkt_buf.sv
// ---------------------------------------------------------------------------
// tb_fifo_data_pkt_buf
// Self-checking bench for fifo_data_pkt_buf. A byte queue models the FIFO
// contents; read data is checked against the queue head, and after a few idle
// cycles every flag and level is checked against the queue size.
// Both FIFO clocks are clk_tb, both resets tb_rst.
// ---------------------------------------------------------------------------
module tb_fifo_data_pkt_buf;
  import fifo_data_pkt_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;
  localparam int AF    = 11;
  localparam int AE    = 4;

  logic clk_tb = 1'b0;
  logic tb_rst = 1'b1;

  always #5 clk_tb = ~clk_tb;

  fifo_data_pkt_buf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fifo_data_pkt_buf #(
    .ADDR_WIDTH       (AW),
    .DATA_WIDTH       (DW),
    .OUT_REG          (0),
    .ALMOST_FULL_NUM  (AF),
    .ALMOST_EMPTY_NUM (AE)
  ) dut (
    .wr_clk (clk_tb),
    .wr_rst (tb_rst),
    .rd_clk (clk_tb),
    .rd_rst (tb_rst),
    .bus    (bus)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_rd  = 0;
  logic [7:0] model[$];
  logic [7:0] last_rd = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check 1 ns after the posedge.
  task automatic step(input logic we, input logic [7:0] wd, input logic re);
    logic       wr_ok, rd_ok;
    logic [7:0] exp;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    if (we && model.size() == DEPTH) chk("full_at_cap", 32'(bus.full), 32'd1);
    if (re && model.size() == 0)     chk("empty_at_zero", 32'(bus.empty), 32'd1);
    wr_ok = we && !bus.full;
    rd_ok = re && !bus.empty;
    @(posedge clk_tb);
    #1;
    if (rd_ok && model.size() > 0) begin
      exp = model.pop_front();
      n_rd++;
      $display("rd %0d data=%02h exp=%02h", n_rd, bus.rd_data, exp);
      chk("rd_data", 32'(bus.rd_data), 32'(exp));
      last_rd = exp;
    end else begin
      chk("rd_hold", 32'(bus.rd_data), 32'(last_rd));
    end
    if (wr_ok) model.push_back(wd);
    @(negedge clk_tb);
  endtask

  // Idle long enough for both pointer crossings, then check all status.
  task automatic settle(input string tag);
    int n;
    repeat (5) step(1'b0, 8'h00, 1'b0);
    n = model.size();
    chk({tag, "_wr_lvl"}, 32'(bus.wr_water_level), 32'(n));
    chk({tag, "_rd_lvl"}, 32'(bus.rd_water_level), 32'(n));
    chk({tag, "_full"},   32'(bus.full),           32'(n == DEPTH));
    chk({tag, "_empty"},  32'(bus.empty),          32'(n == 0));
    chk({tag, "_afull"},  32'(bus.almost_full),    32'(n >= AF));
    chk({tag, "_aempty"}, 32'(bus.almost_empty),   32'(n <= AE));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_empty"},  32'(bus.empty),          32'd1);
    chk({tag, "_aempty"}, 32'(bus.almost_empty),   32'd1);
    chk({tag, "_full"},   32'(bus.full),           32'd0);
    chk({tag, "_afull"},  32'(bus.almost_full),    32'd0);
    chk({tag, "_wr_lvl"}, 32'(bus.wr_water_level), 32'd0);
    chk({tag, "_rd_lvl"}, 32'(bus.rd_water_level), 32'd0);
    chk({tag, "_rdata"},  32'(bus.rd_data),        32'd0);
`ifdef FIFO_DATA_PKT_ERR_FLAG_EN
    chk({tag, "_ovf"},    32'(bus.overflow),       32'd0);
    chk({tag, "_udf"},    32'(bus.underflow),      32'd0);
`endif
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2 * DEPTH && model.size() > 0; i++) step(1'b0, 8'h00, 1'b1);
    chk({tag, "_left"}, 32'(model.size()), 32'd0);
    settle(tag);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pw, pr;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;

    // Power-on reset.
    tb_rst = 1'b1;
    #200;
    check_reset_state("rst");
    @(negedge clk_tb);
    tb_rst = 1'b0;
    settle("idle");

    // Fill to capacity with a repeating 0..255 pattern, then try one more.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_cnt", 32'(model.size()), 32'(DEPTH));
    settle("fill");
    step(1'b1, 8'hEE, 1'b0);
    settle("over");
`ifdef FIFO_DATA_PKT_ERR_FLAG_EN
    chk("ovf_set", 32'(bus.overflow), 32'd1);
`endif

    // Drain everything back in order.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_cnt", 32'(model.size()), 32'd0);
    settle("drain");

    // Threshold walk: one word at a time, all flags checked at each level.
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 8'($urandom), 1'b0);
      settle("thr");
    end
    drain("thr_drain");

    // Reads while empty are ignored; rd_data holds and the pointer stays put.
    repeat (3) step(1'b0, 8'h00, 1'b1);
`ifdef FIFO_DATA_PKT_ERR_FLAG_EN
    chk("udf_set", 32'(bus.underflow), 32'd1);
`endif
    step(1'b1, 8'h77, 1'b0);
    settle("after_udf");
    drain("after_udf_rd");

    // Random traffic in blocks with differing write/read bias.
    for (int b = 0; b < 8; b++) begin
      pw = (b % 3 == 0) ? 80 : (b % 3 == 1) ? 30 : 55;
      pr = (b % 3 == 0) ? 25 : (b % 3 == 1) ? 75 : 50;
      for (int c = 0; c < 400; c++) begin
        step(1'($urandom_range(0, 99) < pw), 8'($urandom), 1'($urandom_range(0, 99) < pr));
      end
      settle("rand");
    end

    // Reset with ~500 words stored: everything discarded.
    for (int i = 0; i < 2000 && model.size() < 500; i++) step(1'b1, 8'($urandom), 1'b0);
    chk("pre_rst_cnt", 32'(model.size()), 32'd500);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #2;
    tb_rst = 1'b1;
    #1;
    model.delete();
    last_rd = 8'h00;
    check_reset_state("midrst");
    @(negedge clk_tb);
    tb_rst = 1'b0;
    settle("post_rst");
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    settle("post_rst_wr");
    drain("post_rst_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
